// File: rtl/multi_ch_capture_if.sv
// RAM control/read bus and UART response handshake of the capture engine.
// master = capture engine side, slave = RAM model / UART side.
interface multi_ch_capture_if #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9
) ();
    logic                     en;
    logic                     we;
    logic [ADDR_W-1:0]        addr;
    logic [NUM_CH*DATA_W-1:0] ch_rdata;
    logic [DATA_W-1:0]        resp_data;
    logic                     send_resp;
    logic                     resp_sent;

    modport master (
        output en, we, addr, resp_data, send_resp,
        input  ch_rdata, resp_sent
    );

    modport slave (
        input  en, we, addr, resp_data, send_resp,
        output ch_rdata, resp_sent
    );
endinterface

// File: rtl/multi_ch_capture.sv
// Decimated circular capture of NUM_CH RAM channels around a trigger, then byte dump of one channel.
// Latency: write strobe drives en/we/addr in the same cycle; each dumped byte costs read + send + ack wait.
// Backpressure: dump holds in DUMP_WAIT until resp_sent; capture has none (RAM always accepts).
module multi_ch_capture #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9,
    parameter int DEC_W  = 4,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              smp_tick,
    input  logic [DEC_W-1:0]  dec_pwr,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              start_cap,
    input  logic              abort,
    input  logic              trigger,
    output logic              armed,
    output logic              capture_done,
    input  logic              start_dump,
    input  logic [CH_W-1:0]   dump_ch,
    output logic              dump_finished,
    multi_ch_capture_if.master bus
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int DCW   = 2**DEC_W - 1;
    localparam int CW    = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE, FILL, ARMED, POST, DONE, DUMP_RD, DUMP_SEND, DUMP_WAIT
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] wptr, rptr, oldest, addr_q, addr_w;
    logic [CW-1:0]     smp_cnt, post_cnt, byte_cnt, pre_len;
    logic [DCW-1:0]    dec_cnt, dec_mask;
    logic [DEC_W-1:0]  dec_pwr_q;
    logic [ADDR_W-1:0] trig_pos_q;
    logic [CH_W-1:0]   ch_sel;
    logic [DATA_W-1:0] resp_data_q, sel_byte;
    logic              send_resp_q;

    logic capturing, strobe, rd_cyc, ram_go, en_w, we_w;
    logic cap_go, dump_ch_ok, fill_done, post_done, trig_arm, enter_done, last_byte;

    assign capturing  = (state == FILL) || (state == ARMED) || (state == POST);
    assign strobe     = capturing && smp_tick && (dec_cnt == '0);
    assign rd_cyc     = (state == DUMP_RD);
    assign dec_mask   = ~({DCW{1'b1}} << dec_pwr_q);
    assign pre_len    = CW'(DEPTH) - {1'b0, trig_pos_q};
    assign cap_go     = start_cap && !abort &&
                        !((state == DUMP_RD) || (state == DUMP_SEND) || (state == DUMP_WAIT));
    assign dump_ch_ok = (32'(dump_ch) < NUM_CH);
    assign fill_done  = (state == FILL) && strobe && ((smp_cnt + 1'b1) == pre_len);
    assign post_done  = (state == POST) && strobe && ((post_cnt + 1'b1) == {1'b0, trig_pos_q});
    assign trig_arm   = (state == ARMED) && trigger;
    assign enter_done = (trig_arm && (trig_pos_q == '0)) || post_done;
    assign last_byte  = (byte_cnt == CW'(DEPTH - 1));

    // RAM strobes are combinational from registered state; abort and reset silence them at once.
    assign ram_go = rst_n && !abort;
    assign we_w   = ram_go && strobe;
    assign en_w   = ram_go && (strobe || rd_cyc);
    assign addr_w = !en_w ? addr_q : (rd_cyc ? rptr : wptr);

    assign bus.en        = en_w;
    assign bus.we        = we_w;
    assign bus.addr      = addr_w;
    assign bus.resp_data = resp_data_q;
    assign bus.send_resp = send_resp_q;

    always_comb begin
        sel_byte = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_sel == CH_W'(k)) sel_byte = bus.ch_rdata[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else if (cap_go) begin
            state_nxt = FILL;
        end else begin
            case (state)
                FILL:      if (fill_done) state_nxt = ARMED;
                ARMED:     if (trigger) state_nxt = (trig_pos_q == '0) ? DONE : POST;
                POST:      if (post_done) state_nxt = DONE;
                DONE:      if (start_dump && dump_ch_ok) state_nxt = DUMP_RD;
                DUMP_RD:   state_nxt = DUMP_SEND;
                DUMP_SEND: state_nxt = DUMP_WAIT;
                DUMP_WAIT: if (bus.resp_sent) state_nxt = last_byte ? DONE : DUMP_RD;
                default:   state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr          <= '0;
            rptr          <= '0;
            oldest        <= '0;
            addr_q        <= '0;
            smp_cnt       <= '0;
            post_cnt      <= '0;
            byte_cnt      <= '0;
            dec_cnt       <= '0;
            dec_pwr_q     <= '0;
            trig_pos_q    <= '0;
            ch_sel        <= '0;
            resp_data_q   <= '0;
            send_resp_q   <= 1'b0;
            armed         <= 1'b0;
            capture_done  <= 1'b0;
            dump_finished <= 1'b0;
        end else begin
            send_resp_q   <= 1'b0;
            dump_finished <= 1'b0;
            addr_q        <= addr_w;
            if (abort) begin
                armed        <= 1'b0;
                capture_done <= 1'b0;
            end else if (cap_go) begin
                wptr         <= '0;
                smp_cnt      <= '0;
                post_cnt     <= '0;
                dec_cnt      <= '0;
                dec_pwr_q    <= dec_pwr;
                trig_pos_q   <= trig_pos;
                armed        <= 1'b0;
                capture_done <= 1'b0;
            end else begin
                if (capturing && smp_tick) dec_cnt <= (dec_cnt + 1'b1) & dec_mask;
                if (strobe) wptr <= wptr + 1'b1;
                if ((state == FILL) && strobe) smp_cnt <= smp_cnt + 1'b1;
                if (fill_done) armed <= 1'b1;
                // A strobe coinciding with the trigger is a pre-trigger sample.
                if (trig_arm) post_cnt <= '0;
                else if ((state == POST) && strobe) post_cnt <= post_cnt + 1'b1;
                if (enter_done) begin
                    armed        <= 1'b0;
                    capture_done <= 1'b1;
                    oldest       <= strobe ? wptr + 1'b1 : wptr;
                end
                case (state)
                    DONE: begin
                        if (start_dump && dump_ch_ok) begin
                            ch_sel   <= dump_ch;
                            rptr     <= oldest;
                            byte_cnt <= '0;
                        end
                    end
                    DUMP_SEND: begin
                        resp_data_q <= sel_byte;
                        send_resp_q <= 1'b1;
                    end
                    DUMP_WAIT: begin
                        if (bus.resp_sent) begin
                            if (last_byte) begin
                                dump_finished <= 1'b1;
                            end else begin
                                rptr     <= rptr + 1'b1;
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multi_ch_capture.sv
// Directed bench for multi_ch_capture: RAM model with address-derived data and a UART ack responder.
module tb_multi_ch_capture;
    logic       clk = 1'b0;
    logic       rst_n, smp_tick, start_cap, abort, trigger, start_dump;
    logic [3:0] dec_pwr;
    logic [8:0] trig_pos;
    logic [1:0] dump_ch;
    logic       armed, capture_done, dump_finished;

    logic resp_pulse = 1'b0;
    logic stray_sent = 1'b0;
    int   resp_delay = 1;
    logic resp_auto  = 1'b0;

    int total = 0;
    int bad   = 0;
    int wr_q[$];
    int rd_q[$];
    int sends[$];
    int fin_cnt = 0;

    multi_ch_capture_if #(.NUM_CH(3), .DATA_W(8), .ADDR_W(9)) bus ();

    multi_ch_capture #(.NUM_CH(3), .DATA_W(8), .ADDR_W(9), .DEC_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .smp_tick(smp_tick), .dec_pwr(dec_pwr),
        .trig_pos(trig_pos), .start_cap(start_cap), .abort(abort), .trigger(trigger),
        .armed(armed), .capture_done(capture_done), .start_dump(start_dump),
        .dump_ch(dump_ch), .dump_finished(dump_finished), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic int f(input int k, input int a);
        return (a * 7 + k * 61 + (a >> 8) * 13) & 255;
    endfunction

    assign bus.resp_sent = resp_pulse | stray_sent;

    always @(posedge clk) begin
        if (bus.en && !bus.we)
            for (int k = 0; k < 3; k++) bus.ch_rdata[k*8 +: 8] <= 8'(f(k, int'(bus.addr)));
    end

    always @(negedge clk) begin
        if (bus.en && bus.we) wr_q.push_back(int'(bus.addr));
        if (bus.en && !bus.we) rd_q.push_back(int'(bus.addr));
        if (bus.send_resp) sends.push_back(int'(bus.resp_data));
        if (dump_finished) fin_cnt++;
    end

    always @(negedge clk) begin
        if (resp_auto && bus.send_resp) begin
            repeat (resp_delay) @(negedge clk);
            resp_pulse = 1'b1;
            @(negedge clk);
            resp_pulse = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; smp_tick = 1'b1; start_cap = 1'b0; abort = 1'b0; trigger = 1'b0;
        start_dump = 1'b0; dec_pwr = '0; trig_pos = '0; dump_ch = '0;
        bus.ch_rdata = '0;
        step(); step();
        total++; if (bus.en !== 1'b0) begin bad++; $display("FAIL reset_en got %0b want 0", bus.en); end
        total++; if (bus.we !== 1'b0) begin bad++; $display("FAIL reset_we got %0b want 0", bus.we); end
        total++; if (bus.addr !== 9'd0) begin bad++; $display("FAIL reset_addr got %0d want 0", bus.addr); end
        total++; if (armed !== 1'b0) begin bad++; $display("FAIL reset_armed got %0b want 0", armed); end
        total++; if (capture_done !== 1'b0) begin bad++; $display("FAIL reset_done got %0b want 0", capture_done); end
        total++; if (bus.send_resp !== 1'b0) begin bad++; $display("FAIL reset_send got %0b want 0", bus.send_resp); end
        total++; if (dump_finished !== 1'b0) begin bad++; $display("FAIL reset_fin got %0b want 0", dump_finished); end
        total++; if (bus.resp_data !== 8'd0) begin bad++; $display("FAIL reset_rdata got %0d want 0", bus.resp_data); end
        total++; if (wr_q.size() != 0) begin bad++; $display("FAIL reset_writes got %0d want 0", wr_q.size()); end
        rst_n = 1'b1; smp_tick = 1'b0;
        step();
    endtask

    task automatic test_basic_capture();
        int mism;
        wr_q.delete();
        dec_pwr = 4'd0; trig_pos = 9'd100; start_cap = 1'b1;
        step();
        start_cap = 1'b0;
        for (int i = 0; i < 412; i++) begin
            if (i == 411) begin
                total++; if (armed !== 1'b0) begin bad++; $display("FAIL early_armed got %0b want 0", armed); end
            end
            smp_tick = 1'b1;
            step();
        end
        smp_tick = 1'b0;
        total++; if (armed !== 1'b1) begin bad++; $display("FAIL armed_after_fill got %0b want 1", armed); end
        total++; if (wr_q.size() != 412) begin bad++; $display("FAIL fill_writes got %0d want 412", wr_q.size()); end
        mism = 0;
        foreach (wr_q[i]) if (wr_q[i] != i) mism++;
        total++; if (mism != 0) begin bad++; $display("FAIL fill_addrs got %0d bad addrs want 0", mism); end
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        wr_q.delete();
        for (int i = 0; i < 100; i++) begin
            if (i == 99) begin
                total++; if (capture_done !== 1'b0) begin bad++; $display("FAIL early_done got %0b want 0", capture_done); end
            end
            smp_tick = 1'b1;
            step();
        end
        smp_tick = 1'b0;
        total++; if (capture_done !== 1'b1) begin bad++; $display("FAIL post_done got %0b want 1", capture_done); end
        total++; if (armed !== 1'b0) begin bad++; $display("FAIL post_armed got %0b want 0", armed); end
        mism = 0;
        foreach (wr_q[i]) if (wr_q[i] != 412 + i) mism++;
        total++; if (mism != 0 || wr_q.size() != 100) begin
            bad++; $display("FAIL post_writes got %0d writes %0d bad want 100 0", wr_q.size(), mism);
        end
        smp_tick = 1'b1;
        repeat (8) step();
        smp_tick = 1'b0;
        total++; if (wr_q.size() != 100) begin bad++; $display("FAIL done_no_write got %0d want 100", wr_q.size()); end
    endtask

    task automatic test_dump();
        int ch, fin0, amism, dmism;
        for (int p = 0; p < 2; p++) begin
            ch = (p == 0) ? 2 : 0;
            rd_q.delete(); sends.delete();
            fin0 = fin_cnt;
            resp_auto = 1'b1; resp_delay = 1;
            dump_ch = 2'(ch); start_dump = 1'b1;
            step();
            start_dump = 1'b0;
            for (int c = 0; c < 6000 && fin_cnt == fin0; c++) step();
            repeat (4) step();
            resp_auto = 1'b0;
            total++; if (fin_cnt - fin0 != 1) begin bad++; $display("FAIL dump%0d_fin got %0d want 1", ch, fin_cnt - fin0); end
            total++; if (sends.size() != 512) begin bad++; $display("FAIL dump%0d_sends got %0d want 512", ch, sends.size()); end
            total++; if (rd_q.size() != 512) begin bad++; $display("FAIL dump%0d_reads got %0d want 512", ch, rd_q.size()); end
            amism = 0; dmism = 0;
            foreach (rd_q[i]) if (rd_q[i] != (i % 512)) amism++;
            foreach (sends[i]) if (sends[i] != f(ch, i % 512)) dmism++;
            total++; if (amism != 0) begin bad++; $display("FAIL dump%0d_addr got %0d bad want 0", ch, amism); end
            total++; if (dmism != 0) begin bad++; $display("FAIL dump%0d_data got %0d bad want 0", ch, dmism); end
            total++; if (capture_done !== 1'b1) begin bad++; $display("FAIL dump%0d_keep_done got %0b want 1", ch, capture_done); end
        end
    endtask

    task automatic test_dump_guards();
        int dmism;
        rd_q.delete(); sends.delete();
        dump_ch = 2'd3; start_dump = 1'b1;
        step();
        start_dump = 1'b0;
        stray_sent = 1'b1;
        step();
        stray_sent = 1'b0;
        repeat (8) step();
        total++; if (rd_q.size() != 0 || sends.size() != 0) begin
            bad++; $display("FAIL bad_ch_dump got %0d reads %0d sends want 0 0", rd_q.size(), sends.size());
        end
        resp_auto = 1'b1; resp_delay = 50;
        dump_ch = 2'd1; start_dump = 1'b1;
        step();
        start_dump = 1'b0;
        for (int c = 0; c < 20 && sends.size() == 0; c++) step();
        resp_delay = 1;
        repeat (45) step();
        total++; if (rd_q.size() != 1 || sends.size() != 1) begin
            bad++; $display("FAIL withhold got %0d reads %0d sends want 1 1", rd_q.size(), sends.size());
        end
        repeat (10) step();
        total++; if (rd_q.size() < 2) begin bad++; $display("FAIL ack_resume got %0d reads want >=2", rd_q.size()); end
        for (int c = 0; c < 300 && rd_q.size() < 11; c++) step();
        abort = 1'b1; start_cap = 1'b1; smp_tick = 1'b1;
        step();
        abort = 1'b0; start_cap = 1'b0;
        resp_auto = 1'b0;
        total++; if (capture_done !== 1'b0) begin bad++; $display("FAIL abort_done got %0b want 0", capture_done); end
        rd_q.delete(); wr_q.delete();
        dmism = 0;
        foreach (sends[i]) if (sends[i] != f(1, i)) dmism++;
        total++; if (sends.size() != 10 || dmism != 0) begin
            bad++; $display("FAIL abort_bytes got %0d sends %0d bad want 10 0", sends.size(), dmism);
        end
        repeat (20) step();
        smp_tick = 1'b0;
        total++; if (sends.size() != 10 || rd_q.size() != 0 || wr_q.size() != 0) begin
            bad++; $display("FAIL after_abort got %0d sends %0d reads %0d writes want 10 0 0",
                            sends.size(), rd_q.size(), wr_q.size());
        end
    endtask

    task automatic test_decimation();
        int wmism;
        wr_q.delete(); rd_q.delete();
        dec_pwr = 4'd2; trig_pos = 9'd0; start_cap = 1'b1;
        step();
        start_cap = 1'b0;
        wmism = 0;
        for (int i = 0; i < 2048; i++) begin
            smp_tick   = 1'b1;
            trigger    = (i == 20);
            start_dump = (i == 30);
            dump_ch    = 2'd0;
            @(negedge clk);
            if (bus.we !== ((i % 4) == 0)) wmism++;
            step();
        end
        smp_tick = 1'b0; trigger = 1'b0; start_dump = 1'b0;
        total++; if (wmism != 0) begin bad++; $display("FAIL dec_pattern got %0d bad cycles want 0", wmism); end
        total++; if (wr_q.size() != 512) begin bad++; $display("FAIL dec_writes got %0d want 512", wr_q.size()); end
        total++; if (armed !== 1'b1) begin bad++; $display("FAIL dec_armed got %0b want 1", armed); end
        total++; if (rd_q.size() != 0) begin bad++; $display("FAIL fill_dump got %0d reads want 0", rd_q.size()); end
        total++; if (capture_done !== 1'b0) begin bad++; $display("FAIL dec_early_done got %0b want 0", capture_done); end
        wr_q.delete();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        total++; if (capture_done !== 1'b1) begin bad++; $display("FAIL tp0_done got %0b want 1", capture_done); end
        total++; if (armed !== 1'b0) begin bad++; $display("FAIL tp0_armed got %0b want 0", armed); end
        smp_tick = 1'b1;
        repeat (12) step();
        smp_tick = 1'b0;
        total++; if (wr_q.size() != 0) begin bad++; $display("FAIL tp0_writes got %0d want 0", wr_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic_capture();
        test_dump();
        test_dump_guards();
        test_decimation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
